lcd_write_arbiter: RTL and testbench

//  Shares the single lcd_write SPI word engine among NREQ burst requesters (init, picture, char overlay).

---
 rtl/lcd_pkg.sv | 12 +
 rtl/lcd_rr_pick.sv | 26 ++
 rtl/lcd_write_arbiter.sv | 120 ++++++++++++
 tb/tb_lcd_write_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared word width, DC flag values and arbiter state encodings for the LCD write path.
package lcd_pkg;
  localparam int LCD_DW = 9;
  localparam logic DC_CMD = 1'b0;
  localparam logic DC_DAT = 1'b1;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;
endpackage

// File: rtl/lcd_rr_pick.sv
// lcd_rr_pick: requester 0 wins outright, else first eligible index at or after i_ptr over 1..NREQ-1.
module lcd_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);
  logic          w_found;
  logic [PW-1:0] w_c;
  always_comb begin
    o_any   = |i_elig;
    o_idx   = '0;
    w_found = i_elig[0];
    w_c     = '0;
    for (int k = 0; k < NREQ - 1; k++) begin
      w_c = PW'((int'(i_ptr) + NREQ - 2 + k) % (NREQ - 1) + 1);
      if (!w_found && i_elig[w_c]) begin
        o_idx   = w_c;
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: burst-locked arbiter sharing the lcd_write word engine among NREQ requesters.
module lcd_write_arbiter import lcd_pkg::*; #(
  parameter int          NREQ   = 3,
  parameter int          DW     = LCD_DW,
  parameter logic [15:0] WD_MAX = 16'd4095
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_init_done,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*DW-1:0] i_req_data,
  input  logic [NREQ-1:0]    i_req_last,
  output logic [NREQ-1:0]    o_req_ack,
  output logic [NREQ-1:0]    o_grant,
  output logic [DW-1:0]      o_data,
  output logic               o_en_write,
  input  logic               i_wr_done,
  output logic               o_wd_err
);
  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          r_state, w_next;
  logic [NREQ-1:0] r_grant, w_grant, r_ack, w_ack, w_elig;
  logic [PW-1:0]   r_owner, w_owner, r_rr, w_rr, w_pick;
  logic [DW-1:0]   r_data, w_data, w_word;
  logic            r_en, w_en, r_err, w_err, r_last, w_last, w_any, w_timeout;
  logic [15:0]     r_cnt, w_cnt;

  assign w_elig    = i_req & {{(NREQ-1){i_init_done}}, 1'b1};
  assign w_word    = i_req_data[int'(r_owner)*DW +: DW];
  assign w_timeout = r_state == S_WAIT && !i_wr_done && r_cnt == WD_MAX - 16'd1;

  lcd_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_elig (w_elig),
    .i_ptr  (r_rr),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_rr    <= PW'(1);
      r_ack   <= '0;
      r_data  <= '0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_grant <= w_grant;
      r_owner <= w_owner;
      r_rr    <= w_rr;
      r_ack   <= w_ack;
      r_data  <= w_data;
      r_en    <= w_en;
      r_err   <= w_err;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_any ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT:  w_next = i_wr_done ? S_GAP : w_timeout ? S_IDLE : S_WAIT;
      S_GAP:   w_next = (!r_last && i_req[r_owner]) ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant = r_grant;
    w_owner = r_owner;
    w_rr    = r_rr;
    w_ack   = '0;
    w_data  = r_data;
    w_en    = r_en;
    w_err   = r_err | w_timeout;
    w_last  = r_last;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_owner = w_any ? w_pick : r_owner;
        w_grant = w_any ? ONE << w_pick : '0;
      end
      S_LOAD: begin
        w_data = w_word;
        w_en   = 1'b1;
        w_cnt  = '0;
      end
      S_WAIT: begin
        w_en    = !(i_wr_done || w_timeout);
        w_ack   = i_wr_done ? ONE << r_owner : '0;
        w_last  = i_wr_done ? i_req_last[r_owner] : r_last;
        w_grant = w_timeout ? '0 : r_grant;
        w_cnt   = r_cnt + 16'd1;
      end
      S_GAP: begin
        w_grant = (r_last || !i_req[r_owner]) ? '0 : r_grant;
        // only a completed burst advances the round-robin pointer; init never moves it
        if (r_last && r_owner != '0)
          w_rr = (r_owner == PW'(NREQ - 1)) ? PW'(1) : r_owner + PW'(1);
      end
      default: w_grant = '0;
    endcase
  end

  assign o_grant    = r_grant;
  assign o_req_ack  = r_ack;
  assign o_data     = r_data;
  assign o_en_write = r_en;
  assign o_wd_err   = r_err;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed bursts with a scoreboard of expected {ack owner, word} pairs.
module tb_lcd_write_arbiter;
  localparam int N   = 8;
  localparam int TMO = 200;

  typedef struct packed {
    logic [2:0] who;
    logic [8:0] dat;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1, init_done = 1'b0;
  logic        m_done = 1'b0, s_done = 1'b0, model_on = 1'b1;
  logic        q_a [3];
  logic        l_a [3];
  logic [8:0]  d_a [3];
  logic [8:0]  tbl [12][4];
  logic [2:0]  req, req_last, req_ack, grant;
  logic [26:0] req_data;
  logic [8:0]  data;
  logic        en_write, wd_err, wr_done;
  exp_t        q[$];
  int          n_pass = 0, n_tot = 0, mc = 0;

  assign req      = {q_a[2], q_a[1], q_a[0]};
  assign req_last = {l_a[2], l_a[1], l_a[0]};
  assign req_data = {d_a[2], d_a[1], d_a[0]};
  assign wr_done  = m_done | s_done;

  lcd_write_arbiter #(.NREQ(3), .DW(9), .WD_MAX(16'd20)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_init_done (init_done),
    .i_req       (req),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ack   (req_ack),
    .o_grant     (grant),
    .o_data      (data),
    .o_en_write  (en_write),
    .i_wr_done   (wr_done),
    .o_wd_err    (wd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // lcd_write model: wr_done pulse after en_write has been high for N cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      m_done = 1'b0;
      if (en_write && model_on && !rst) begin
        if (mc == N - 1) begin
          m_done = 1'b1;
          mc = 0;
        end else mc++;
      end else mc = 0;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (|req_ack) begin
        if (q.size() == 0) chk("ack_unexpected", {29'd0, req_ack}, 32'd0);
        else begin
          e = q.pop_front();
          chk("ack_who", {29'd0, req_ack}, {29'd0, e.who});
          chk("ack_data", {23'd0, data}, {23'd0, e.dat});
          chk("ack_grant", {29'd0, grant}, {29'd0, e.who});
        end
      end
    end
  end

  task automatic push(input logic [2:0] who, input logic [8:0] dat);
    q.push_back('{who: who, dat: dat});
  endtask

  task automatic wait_ack(input int idx);
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!req_ack[idx] && t < TMO);
    if (!req_ack[idx]) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_en(input logic lvl);
    int t = 0;
    while (en_write !== lvl && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    chk("en_wait", {31'd0, en_write}, {31'd0, lvl});
  endtask

  task automatic burst(input int idx, input int id, input int n);
    for (int k = 0; k < n; k++) begin
      d_a[idx] = tbl[id][k];
      l_a[idx] = (k == n - 1);
      q_a[idx] = 1'b1;
      wait_ack(idx);
    end
    q_a[idx] = 1'b0;
    l_a[idx] = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) q_a[i] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_grant"}, {29'd0, grant}, 32'd0);
    chk({nm, "_ack"}, {29'd0, req_ack}, 32'd0);
    chk({nm, "_data"}, {23'd0, data}, 32'd0);
    chk({nm, "_en"}, {31'd0, en_write}, 32'd0);
    chk({nm, "_wderr"}, {31'd0, wd_err}, 32'd0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 3; i++) begin
      q_a[i] = 1'b0;
      l_a[i] = 1'b0;
      d_a[i] = '0;
    end
    for (int r = 0; r < 12; r++)
      for (int k = 0; k < 4; k++) tbl[r][k] = '0;
    tbl[0][0] = 9'h12A; tbl[0][1] = 9'h155; tbl[0][2] = 9'h1FF;
    tbl[1][0] = 9'h0A5; tbl[2][0] = 9'h001;
    tbl[3][0] = 9'h120; tbl[3][1] = 9'h134; tbl[3][2] = 9'h156; tbl[3][3] = 9'h178;
    tbl[4][0] = 9'h011; tbl[5][0] = 9'h1C3;
    tbl[6][0] = 9'h1A1; tbl[7][0] = 9'h1A2; tbl[8][0] = 9'h0B1; tbl[9][0] = 9'h0B2;
    tbl[10][0] = 9'h1EE; tbl[11][0] = 9'h1DD;
    @(posedge clk); #1;
    do_reset();
    chk_zero("reset");

    // 1: single 3-word burst from requester 1
    init_done = 1'b1;
    push(3'b010, 9'h12A); push(3'b010, 9'h155); push(3'b010, 9'h1FF);
    fork
      burst(1, 0, 3);
      begin
        @(posedge clk); #1;
        chk("t1_grant_c1", {29'd0, grant}, 32'h2);
        chk("t1_en_c1", {31'd0, en_write}, 32'd0);
        @(posedge clk); #1;
        chk("t1_en_c2", {31'd0, en_write}, 32'd1);
        chk("t1_data_c2", {23'd0, data}, 32'h12A);
      end
    join
    @(posedge clk); #1;
    chk("t1_grant_end", {29'd0, grant}, 32'd0);
    chk("t1_en_end", {31'd0, en_write}, 32'd0);

    // 2: init gating
    do_reset();
    init_done = 1'b0;
    d_a[1] = tbl[1][0]; d_a[2] = tbl[1][0]; l_a[1] = 1'b1; l_a[2] = 1'b1;
    q_a[1] = 1'b1; q_a[2] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t2_gated", {29'd0, grant}, 32'd0);
    end
    init_done = 1'b1;
    @(posedge clk); #1;
    chk("t2_after_init", {29'd0, grant}, 32'h2);
    do_reset();
    init_done = 1'b0;
    q_a[1] = 1'b1;
    push(3'b001, 9'h001);
    fork
      burst(0, 2, 1);
      begin
        @(posedge clk); #1;
        chk("t2_init_grant", {29'd0, grant}, 32'h1);
      end
    join
    q_a[1] = 1'b0;
    l_a[1] = 1'b0;
    l_a[2] = 1'b0;
    @(posedge clk); #1;
    chk("t2_idle", {29'd0, grant}, 32'd0);

    // 3: requester 0 cannot break requester 2's locked burst
    do_reset();
    init_done = 1'b1;
    push(3'b100, 9'h120); push(3'b100, 9'h134); push(3'b100, 9'h156); push(3'b100, 9'h178);
    push(3'b001, 9'h011); push(3'b010, 9'h1C3);
    fork
      burst(2, 3, 4);
      begin
        wait_ack(2);
        fork
          burst(0, 4, 1);
          burst(1, 5, 1);
        join
      end
    join

    // 4: round-robin with continuous single-word bursts
    do_reset();
    push(3'b010, 9'h1A1); push(3'b100, 9'h0B1); push(3'b010, 9'h1A2); push(3'b100, 9'h0B2);
    fork
      for (int i = 0; i < 2; i++) burst(1, 6 + i, 1);
      for (int i = 0; i < 2; i++) burst(2, 8 + i, 1);
    join

    // 5: watchdog abort after WD_MAX cycles of en_write
    do_reset();
    model_on = 1'b0;
    d_a[1] = tbl[10][0]; l_a[1] = 1'b1; q_a[1] = 1'b1;
    wait_en(1'b1);
    c = 0;
    while (en_write && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    q_a[1] = 1'b0;
    l_a[1] = 1'b0;
    chk("t5_wd_len", c, 32'd20);
    chk("t5_wd_err", {31'd0, wd_err}, 32'd1);
    chk("t5_grant", {29'd0, grant}, 32'd0);
    model_on = 1'b1;
    push(3'b100, 9'h1DD);
    burst(2, 11, 1);
    chk("t5_wd_sticky", {31'd0, wd_err}, 32'd1);

    // 6: reset in WAIT, then a stale wr_done
    do_reset();
    d_a[1] = tbl[5][0]; l_a[1] = 1'b1; q_a[1] = 1'b1;
    wait_en(1'b1);
    @(posedge clk); #1;
    q_a[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("t6_rst");
    s_done = 1'b1;
    @(posedge clk); #1;
    s_done = 1'b0;
    chk("t6_stale_ack", {29'd0, req_ack}, 32'd0);
    chk("t6_stale_en", {31'd0, en_write}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
